// File: rtl/btn_evt_pkg.sv
// Shared types for the button gesture decoder: FSM state enum and event codes.
// Optional feature macro: BTN_EVT_OVERFLOW_EN (sticky dropped-event flag).
package btn_evt_pkg;

    // Gesture FSM states
    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_LONG_HELD      = 3'd2,
        ST_WAIT_SECOND    = 3'd3,
        ST_SECOND_PRESSED = 3'd4
    } state_e;

    typedef logic [1:0] evt_code_t;

    // Event codes presented on evt_code (3 is reserved)
    localparam evt_code_t EVT_SINGLE = 2'd0;
    localparam evt_code_t EVT_DOUBLE = 2'd1;
    localparam evt_code_t EVT_LONG   = 2'd2;

endpackage

// File: rtl/button_event_decoder_slot.sv
// btn_evt_slot: single-entry valid/ready holding register for gesture events.
// A new event loads when the slot is empty or is being drained on the same edge;
// otherwise it is dropped. With BTN_EVT_OVERFLOW_EN a sticky flag records drops.
module btn_evt_slot
    import btn_evt_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      emit_i,
    input  evt_code_t code_i,
    input  logic      ready_i,
    output logic      valid_o,
    output evt_code_t code_o
`ifdef BTN_EVT_OVERFLOW_EN
    ,
    output logic      overflow_o
`endif
);

    logic      valid_q, valid_d;
    evt_code_t code_q,  code_d;
    logic      load;
    logic      accept;

    assign accept = valid_q && ready_i;
    assign load   = emit_i && (!valid_q || ready_i);

    // Next slot contents: a reload wins over a plain drain so valid stays high
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        if (load) begin
            valid_d = 1'b1;
            code_d  = code_i;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            code_q  <= EVT_SINGLE;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

    assign valid_o = valid_q;
    assign code_o  = code_q;

`ifdef BTN_EVT_OVERFLOW_EN
    logic overflow_q, overflow_d;
    logic drop;

    assign drop = emit_i && valid_q && !ready_i;

    // Overflow is sticky until reset
    always_comb begin
        overflow_d = overflow_q | drop;
    end

    // Overflow register
    always_ff @(posedge clk) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    assign overflow_o = overflow_q;
`endif

endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies a debounced active-low button level into
// SINGLE / DOUBLE / LONG gesture events and hands them out over valid/ready.
// Optional feature macro: BTN_EVT_OVERFLOW_EN adds the sticky evt_overflow port.
module button_event_decoder
    import btn_evt_pkg::*;
#(
    parameter int LONG_CYCLES   = 16,
    parameter int DCLICK_WINDOW = 8,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Din,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_code
`ifdef BTN_EVT_OVERFLOW_EN
    ,
    output logic       evt_overflow
`endif
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(DCLICK_WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             din_q;
    logic             press_edge;
    logic             emit;
    evt_code_t        emit_code;

    // din_q resets to "pressed" so a button held through reset cannot fire
    assign press_edge = !Din && din_q;

    // Next-state, counter and event emission; every counting state exits
    // on its terminal compare, so the counter never wraps
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_code = EVT_SINGLE;
        case (state_q)
            ST_IDLE: begin
                if (press_edge) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end
            end
            ST_PRESSED: begin
                if (Din) begin
                    state_d = ST_WAIT_SECOND;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    emit      = 1'b1;
                    emit_code = EVT_LONG;
                    state_d   = ST_LONG_HELD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LONG_HELD: begin
                if (Din) state_d = ST_IDLE;
            end
            ST_WAIT_SECOND: begin
                // A second press beats the window expiring on the same edge
                if (!Din) begin
                    state_d = ST_SECOND_PRESSED;
                end else if (cnt_q == WIN_LAST) begin
                    emit      = 1'b1;
                    emit_code = EVT_SINGLE;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SECOND_PRESSED: begin
                // Second press length is irrelevant: no LONG from here
                if (Din) begin
                    emit      = 1'b1;
                    emit_code = EVT_DOUBLE;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and input sample registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            din_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= Din;
        end
    end

    btn_evt_slot u_slot (
        .clk        (clk),
        .reset      (reset),
        .emit_i     (emit),
        .code_i     (emit_code),
        .ready_i    (evt_ready),
        .valid_o    (evt_valid),
        .code_o     (evt_code)
`ifdef BTN_EVT_OVERFLOW_EN
        ,
        .overflow_o (evt_overflow)
`endif
    );

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder: timestamp-based gesture model,
// per-cycle compare, directed gestures with literal expectations, then random
// button activity. Honors BTN_EVT_OVERFLOW_EN when defined.
module tb_button_event_decoder;

    localparam int L = 16;
    localparam int W = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       din   = 1'b1;
    logic       rdy   = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_code;
`ifdef BTN_EVT_OVERFLOW_EN
    logic       evt_overflow;
`endif

    int  checks = 0;
    int  errors = 0;
    bit  run    = 1'b0;

    always #5 clk = ~clk;

    button_event_decoder #(.LONG_CYCLES(L), .DCLICK_WINDOW(W), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .Din          (din),
        .evt_ready    (rdy),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code)
`ifdef BTN_EVT_OVERFLOW_EN
        ,
        .evt_overflow (evt_overflow)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: gestures judged by edge timestamps (press edge index,
    // release edge index) rather than a running counter.
    int   n    = 0;
    int   ph   = 0;      // 0 idle, 1 first press, 2 long held, 3 gap, 4 second press
    int   t0   = 0;
    int   trel = 0;
    logic prev = 1'b0;
    bit   mv   = 1'b0;
    int   mc   = 0;
    bit   mo   = 1'b0;

    always @(posedge clk) begin
        bit e;
        int ec;
        e  = 1'b0;
        ec = 0;
        if (reset) begin
            ph = 0; prev = 1'b0; mv = 1'b0; mc = 0; mo = 1'b0;
        end else begin
            case (ph)
                0: if (!din && prev) begin ph = 1; t0 = n; end
                1: if (din) begin ph = 3; trel = n; end
                   else if (n - t0 == L) begin e = 1'b1; ec = 2; ph = 2; end
                2: if (din) ph = 0;
                3: if (!din) ph = 4;
                   else if (n - trel == W) begin e = 1'b1; ec = 0; ph = 0; end
                4: if (din) begin e = 1'b1; ec = 1; ph = 0; end
                default: ph = 0;
            endcase
            prev = din;
            if (e) begin
                if (!mv || rdy) begin mv = 1'b1; mc = ec; end
                else mo = 1'b1;
            end else if (mv && rdy) begin
                mv = 1'b0;
            end
        end
        n++;
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (run) begin
            chk("valid", {31'd0, evt_valid}, {31'd0, mv});
            if (mv) chk("code", {30'd0, evt_code}, mc);
`ifdef BTN_EVT_OVERFLOW_EN
            chk("overflow", {31'd0, evt_overflow}, {31'd0, mo});
`endif
        end
    end

    task automatic cyc(input logic d, input logic r);
        din = d;
        rdy = r;
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic v, input logic [1:0] c);
        chk({nm, "_valid"}, {31'd0, evt_valid}, {31'd0, v});
        if (v) chk({nm, "_code"}, {30'd0, evt_code}, {30'd0, c});
    endtask

    initial begin
        logic lvl;
        int   len;

        // reset
        repeat (3) cyc(1'b1, 1'b0);
        run = 1'b1;
        chk("rst_valid", {31'd0, evt_valid}, 0);
        chk("rst_code", {30'd0, evt_code}, 0);
        reset = 1'b0;
        repeat (2) cyc(1'b1, 1'b0);

        // SINGLE: 5 low, valid rises W edges after the release sample
        repeat (5) cyc(1'b0, 1'b0);
        repeat (8) cyc(1'b1, 1'b0);
        lit("single_early", 1'b0, 2'd0);
        cyc(1'b1, 1'b0);
        lit("single", 1'b1, 2'd0);
        repeat (3) cyc(1'b1, 1'b0);
        lit("single_hold", 1'b1, 2'd0);
        cyc(1'b1, 1'b1);
        lit("single_ack", 1'b0, 2'd0);

        // LONG: fires on edge 16 while held, release adds nothing
        repeat (16) cyc(1'b0, 1'b0);
        lit("long_early", 1'b0, 2'd0);
        cyc(1'b0, 1'b0);
        lit("long", 1'b1, 2'd2);
        repeat (4) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        lit("long_ack", 1'b0, 2'd0);
        repeat (12) cyc(1'b1, 1'b0);
        lit("long_no_extra", 1'b0, 2'd0);

        // DOUBLE: low 4, high 3, low 4, high
        repeat (4) cyc(1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b0);
        lit("dbl_early", 1'b0, 2'd0);
        cyc(1'b1, 1'b0);
        lit("dbl", 1'b1, 2'd1);
        repeat (12) cyc(1'b1, 1'b0);
        lit("dbl_no_single", 1'b1, 2'd1);
`ifdef BTN_EVT_OVERFLOW_EN
        chk("dbl_no_ovf", {31'd0, evt_overflow}, 0);
`endif
        cyc(1'b1, 1'b1);
        lit("dbl_ack", 1'b0, 2'd0);

        // LONG emitted on the same edge a pending SINGLE is accepted
        repeat (3) cyc(1'b0, 1'b0);
        repeat (9) cyc(1'b1, 1'b0);
        lit("pend_single", 1'b1, 2'd0);
        repeat (16) cyc(1'b0, 1'b0);
        lit("pend_still", 1'b1, 2'd0);
        cyc(1'b0, 1'b1);
        lit("reload_long", 1'b1, 2'd2);
`ifdef BTN_EVT_OVERFLOW_EN
        chk("reload_no_ovf", {31'd0, evt_overflow}, 0);
`endif
        cyc(1'b1, 1'b1);
        lit("reload_ack", 1'b0, 2'd0);

        // Two SINGLEs with no consumer: second dropped
        repeat (3) cyc(1'b0, 1'b0);
        repeat (9) cyc(1'b1, 1'b0);
        lit("ovf_first", 1'b1, 2'd0);
        repeat (3) cyc(1'b0, 1'b0);
        repeat (9) cyc(1'b1, 1'b0);
        lit("ovf_kept", 1'b1, 2'd0);
`ifdef BTN_EVT_OVERFLOW_EN
        chk("ovf_set", {31'd0, evt_overflow}, 1);
`endif
        cyc(1'b1, 1'b1);
        lit("ovf_ack", 1'b0, 2'd0);

        // Button held through reset: no event until released and re-pressed
        reset = 1'b1;
        repeat (2) cyc(1'b0, 1'b0);
        reset = 1'b0;
`ifdef BTN_EVT_OVERFLOW_EN
        chk("ovf_cleared", {31'd0, evt_overflow}, 0);
`endif
        repeat (30) cyc(1'b0, 1'b0);
        repeat (15) cyc(1'b1, 1'b0);
        lit("held_rst_none", 1'b0, 2'd0);
        repeat (3) cyc(1'b0, 1'b0);
        repeat (8) cyc(1'b1, 1'b0);
        lit("after_rst_early", 1'b0, 2'd0);
        cyc(1'b1, 1'b0);
        lit("after_rst_single", 1'b1, 2'd0);
        cyc(1'b1, 1'b1);

        // Reset mid-gesture abandons it
        repeat (5) cyc(1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b0);
        reset = 1'b0;
        repeat (12) cyc(1'b1, 1'b0);
        lit("mid_rst_none", 1'b0, 2'd0);

        // Random button activity, model compare runs every cycle
        lvl = 1'b1;
        repeat (160) begin
            lvl = ~lvl;
            len = $urandom_range(1, 25);
            repeat (len) begin
                reset = ($urandom_range(0, 299) == 0);
                cyc(lvl, $urandom_range(0, 3) != 0);
            end
        end
        reset = 1'b0;
        repeat (3) cyc(1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
